// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
//   Shared definitions for pipelined_shifter and its register slice:
//   - control encodings for the five shift modes plus pass-through
//   - log2 helper used to size the shift-amount field
//   - regAfterStep(): decides where the pipeline registers sit
//
//   Optional feature macro used by the design: SHIFTER_FLAGS_EN
// ---------------------------------------------------------------------------
package shifter_pkg;

  // Values 3'b110 and 3'b111 are unnamed and behave like SHIFTER_PASS.
  typedef enum logic [2:0] {
    SHIFTER_SLL  = 3'b000,
    SHIFTER_SRL  = 3'b001,
    SHIFTER_SRA  = 3'b010,
    SHIFTER_ROR  = 3'b011,
    SHIFTER_ROL  = 3'b100,
    SHIFTER_PASS = 3'b101
  } shiftOpT;

  localparam int SHIFTER_MAX_WIDTH = 64;
  localparam int SHIFTER_MAX_LOG2  = $clog2(SHIFTER_MAX_WIDTH);

  // Number of shift-amount bits (and rotate stages) for a data width.
  function automatic int shiftLog2(input int width);
    return $clog2(width);
  endfunction

  // The datapath is a chain of numSteps combinational steps
  // (log2(WIDTH) rotate steps followed by the mask step). Register j of
  // pipeStages sits after floor(j*numSteps/(pipeStages+1)) steps, which
  // spreads the registers evenly and never places one after the mask step,
  // so the output is always the mask step driven by the last register.
  function automatic bit regAfterStep(input int step, input int pipeStages,
                                      input int numSteps);
    bit hit;
    hit = 1'b0;
    for (int j = 1; j <= pipeStages; j++) begin
      if ((j * numSteps) / (pipeStages + 1) == step + 1) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/shifter_pipe_reg.sv
// ---------------------------------------------------------------------------
// shifter_pipe_reg
//   One valid/ready register slice. Loads when empty or when the downstream
//   side takes the current contents, so a full pipe of slices sustains one
//   transfer per cycle and never inserts bubbles while stalled.
//
//   Ports:
//     clock, resetN        rising-edge clock, asynchronous active-low reset
//     inValid / inReady    upstream handshake (inReady is this slice's load)
//     inData               payload from upstream
//     outValid / outReady  downstream handshake
//     outData              registered payload, stable while stalled
// ---------------------------------------------------------------------------
module shifter_pipe_reg #(
  parameter int PAYLOAD_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [PAYLOAD_WIDTH-1:0] inData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [PAYLOAD_WIDTH-1:0] outData
);

  logic load;

  assign load    = !outValid || outReady;
  assign inReady = load;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      outValid <= 1'b0;
      // NOTE: the payload is reset as well as the valid bit, so the visible
      // result, tag and flags read zero after reset rather than stale data.
      outData  <= '0;
    end else if (load) begin
      outValid <= inValid;
      if (inValid) outData <= inData;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_shifter
//   Parametrised barrel shifter with valid/ready handshake. The value is
//   rotated right through log2(WIDTH) stages of 2^k bits, then a fill mask
//   turns the rotation into SLL/SRL/SRA. PIPE_STAGES register slices are
//   spread over the steps; with PIPE_STAGES=0 the unit is combinational.
//
//   Optional feature macro: SHIFTER_FLAGS_EN (carryOut / zeroFlag). Without
//   it both flag outputs are tied low and no flag state exists.
//
//   Ports:
//     clock, resetN        rising-edge clock, asynchronous active-low reset
//     inValid / inReady    operation offered / accepted
//     control              000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL,
//                          101..111 pass-through
//     operantA             value to shift
//     operantB             shift amount, low log2(WIDTH) bits used
//     inTag                opaque tag carried with the operation
//     outValid / outReady  result available / taken by the consumer
//     result, outTag       shifted value and its tag
//     carryOut, zeroFlag   last bit shifted out, result==0
// ---------------------------------------------------------------------------
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [2:0]           control,
  input  logic [WIDTH-1:0]     operantA,
  input  logic [WIDTH-1:0]     operantB,
  input  logic [TAG_WIDTH-1:0] inTag,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [WIDTH-1:0]     result,
  output logic [TAG_WIDTH-1:0] outTag,
  output logic                 carryOut,
  output logic                 zeroFlag
);

  localparam int AMT_W     = shiftLog2(WIDTH);
  localparam int NUM_STEPS = AMT_W + 1;

  // Everything a step needs to continue the operation. The carry is computed
  // up front from operantA, so operantA itself never has to travel.
  typedef struct packed {
    logic [WIDTH-1:0]     data;     // partially rotated value
    logic [WIDTH-1:0]     mask;     // 1 = keep rotated bit, 0 = fill
    logic [AMT_W-1:0]     amt;      // right-rotate amount still to apply
    logic [2:0]           control;
    logic                 msb;      // operantA[WIDTH-1], the SRA fill bit
    logic [TAG_WIDTH-1:0] tag;
`ifdef SHIFTER_FLAGS_EN
    logic                 carry;
`endif
  } stageT;

  // node[s] feeds rotate step s; node[AMT_W] feeds the mask step.
  stageT node [0:AMT_W];
  stageT comb [0:AMT_W-1];
  logic  vld  [0:AMT_W];
  logic  rdy  [0:AMT_W];

  stageT            prep;
  logic [AMT_W-1:0] amt;
  logic             unusedHighB;

  assign amt         = operantB[AMT_W-1:0];
  assign unusedHighB = ^operantB[WIDTH-1:AMT_W];

  function automatic stageT rotateStage(input stageT p, input int s);
    stageT r;
    int    sh;
    r  = p;
    sh = 1 << s;
    if (p.amt[s]) r.data = (p.data >> sh) | (p.data << (WIDTH - sh));
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Operation decode: rotate amount, fill mask and carry source.
  // Left shifts and rotates become a right rotate by (WIDTH - amt) mod WIDTH,
  // which is just the two's-complement negation in AMT_W bits.
  // -------------------------------------------------------------------------
`ifdef SHIFTER_FLAGS_EN
  logic [AMT_W-1:0] carryIdx;
  logic             carryLive;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    prep.data    = operantA;
    prep.mask    = '1;
    prep.amt     = '0;
    prep.control = control;
    prep.msb     = operantA[WIDTH-1];
    prep.tag     = inTag;
`ifdef SHIFTER_FLAGS_EN
    carryIdx     = '0;
    carryLive    = 1'b0;
`endif
    case (control)
      SHIFTER_SLL: begin
        prep.amt  = -amt;
        prep.mask = '1 << amt;
`ifdef SHIFTER_FLAGS_EN
        carryIdx  = -amt;
        carryLive = 1'b1;
`endif
      end
      SHIFTER_SRL, SHIFTER_SRA: begin
        prep.amt  = amt;
        prep.mask = '1 >> amt;
`ifdef SHIFTER_FLAGS_EN
        carryIdx  = amt - AMT_W'(1);
        carryLive = 1'b1;
`endif
      end
      SHIFTER_ROR: begin
        prep.amt  = amt;
`ifdef SHIFTER_FLAGS_EN
        carryIdx  = amt - AMT_W'(1);
        carryLive = 1'b1;
`endif
      end
      SHIFTER_ROL: begin
        prep.amt  = -amt;
`ifdef SHIFTER_FLAGS_EN
        carryIdx  = -amt;
        carryLive = 1'b1;
`endif
      end
      default: ;  // pass-through: no rotation, full mask
    endcase
`ifdef SHIFTER_FLAGS_EN
    // For rotates the bit that wraps around is the same bit of operantA that
    // a shift would have dropped, so one index covers all four modes.
    prep.carry = carryLive && (amt != '0) && operantA[carryIdx];
`endif
  end

  assign node[0] = prep;
  assign vld[0]  = inValid;
  assign inReady = rdy[0];

  // -------------------------------------------------------------------------
  // Rotate steps with optional register slices between them.
  // -------------------------------------------------------------------------
  for (genvar s = 0; s < AMT_W; s++) begin : gStep
    assign comb[s] = rotateStage(node[s], s);

    if (regAfterStep(s, PIPE_STAGES, NUM_STEPS)) begin : gReg
      shifter_pipe_reg #(
        .PAYLOAD_WIDTH($bits(stageT))
      ) uReg (
        .clock    (clock),
        .resetN   (resetN),
        .inValid  (vld[s]),
        .inReady  (rdy[s]),
        .inData   (comb[s]),
        .outValid (vld[s+1]),
        .outReady (rdy[s+1]),
        .outData  (node[s+1])
      );
    end else begin : gWire
      assign node[s+1] = comb[s];
      assign vld[s+1]  = vld[s];
      assign rdy[s]    = rdy[s+1];
    end
  end

  if (PIPE_STAGES == 0) begin : gNoState
    logic unusedClockReset;
    assign unusedClockReset = clock ^ resetN;
  end

  // -------------------------------------------------------------------------
  // Mask step: replace the wrapped-around bits with the fill value.
  // -------------------------------------------------------------------------
  stageT            last;
  logic [WIDTH-1:0] fill;

  assign last     = node[AMT_W];
  assign fill     = (last.control == SHIFTER_SRA && last.msb) ? '1 : '0;
  assign result   = (last.data & last.mask) | (fill & ~last.mask);
  assign outTag   = last.tag;
  assign outValid = vld[AMT_W];
  assign rdy[AMT_W] = outReady;

`ifdef SHIFTER_FLAGS_EN
  assign carryOut = last.carry;
  // Gated with valid so an empty (reset) pipe reports zeroFlag=0.
  assign zeroFlag = vld[AMT_W] && (result == '0);
`else
  assign carryOut = 1'b0;
  assign zeroFlag = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_shifter
//   Bench for pipelined_shifter (WIDTH=32, PIPE_STAGES=2, TAG_WIDTH=4) plus
//   a PIPE_STAGES=0 instance for the combinational mode. Expected results
//   come from a behavioural shift model and are queued at acceptance.
// ---------------------------------------------------------------------------
module tb_pipelined_shifter;

  localparam int W = 32;
  localparam int P = 2;
  localparam int T = 4;

  logic         clock;
  logic         resetN;
  logic         inValid;
  logic         outReady;
  logic [2:0]   control;
  logic [W-1:0] operantA;
  logic [W-1:0] operantB;
  logic [T-1:0] inTag;

  logic         inReady, outValid, carryOut, zeroFlag;
  logic [W-1:0] result;
  logic [T-1:0] outTag;

  logic         cInReady, cOutValid, cCarryOut, cZeroFlag;
  logic [W-1:0] cResult;
  logic [T-1:0] cOutTag;

  typedef struct packed {
    logic [2:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [T-1:0] tag;
  } opT;

  typedef struct packed {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    logic         carry;
  } expT;

  expT sb[$];
  int  checks   = 0;
  int  failures = 0;

  pipelined_shifter #(.WIDTH(W), .PIPE_STAGES(P), .TAG_WIDTH(T)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .control(control), .operantA(operantA), .operantB(operantB),
    .inTag(inTag), .outValid(outValid), .outReady(outReady),
    .result(result), .outTag(outTag), .carryOut(carryOut),
    .zeroFlag(zeroFlag)
  );

  pipelined_shifter #(.WIDTH(W), .PIPE_STAGES(0), .TAG_WIDTH(T)) dutComb (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(cInReady),
    .control(control), .operantA(operantA), .operantB(operantB),
    .inTag(inTag), .outValid(cOutValid), .outReady(outReady),
    .result(cResult), .outTag(cOutTag), .carryOut(cCarryOut),
    .zeroFlag(cZeroFlag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: plain shift operators, rotates built from shifts.
  function automatic logic [W-1:0] model(input opT op);
    int n;
    logic [W-1:0] r;
    n = int'(op.b[4:0]);
    case (op.c)
      3'd0: r = op.a << n;
      3'd1: r = op.a >> n;
      3'd2: r = $signed(op.a) >>> n;
      3'd3: r = (n == 0) ? op.a : ((op.a >> n) | (op.a << (W - n)));
      3'd4: r = (n == 0) ? op.a : ((op.a << n) | (op.a >> (W - n)));
      default: r = op.a;
    endcase
    return r;
  endfunction

  function automatic logic modelCarry(input opT op);
    int n;
    logic [W-1:0] r;
    logic c;
    n = int'(op.b[4:0]);
    r = model(op);
    c = 1'b0;
    if (n != 0) begin
      case (op.c)
        3'd0:       c = op.a[W-n];
        3'd1, 3'd2: c = op.a[n-1];
        3'd3:       c = r[W-1];
        3'd4:       c = r[0];
        default:    c = 1'b0;
      endcase
    end
    return c;
  endfunction

  function automatic expT expect_of(input opT op);
    expT e;
    e.res   = model(op);
    e.tag   = op.tag;
    e.carry = modelCarry(op);
    return e;
  endfunction

  function automatic opT mkOp(input logic [2:0] c, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [T-1:0] tag);
    opT op;
    op.c = c; op.a = a; op.b = b; op.tag = tag;
    return op;
  endfunction

  task automatic driveOp(input opT op);
    inValid  = 1'b1;
    control  = op.c;
    operantA = op.a;
    operantB = op.b;
    inTag    = op.tag;
  endtask

  task automatic idleInputs();
    inValid  = 1'b0;
    control  = 3'd0;
    operantA = '0;
    operantB = '0;
    inTag    = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    #3;
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b want=0", outValid); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL reset_inReady got=%b want=1", inReady); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if (outTag !== '0) begin failures++; $display("FAIL reset_outTag got=%h want=0", outTag); end
    checks++; if (carryOut !== 1'b0 || zeroFlag !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", carryOut, zeroFlag); end
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    checks++; if (inReady !== 1'b1 || outValid !== 1'b0) begin failures++; $display("FAIL post_reset_handshake got=%b%b want=10", inReady, outValid); end
  endtask

  // -------------------------------------------------------------------------
  // Single operations issued into an empty pipe: latency, value, tag, carry.
  task automatic test_directed();
    opT  ops[12];
    expT e;
    int  lat;
    ops[0]  = mkOp(3'd2, 32'h8000_0010, 32'd4,  4'h5);
    ops[1]  = mkOp(3'd4, 32'h8000_0001, 32'd1,  4'h6);
    ops[2]  = mkOp(3'd3, 32'h8000_0001, 32'd33, 4'h7);
    ops[3]  = mkOp(3'd0, 32'h0000_0001, 32'd31, 4'h1);
    ops[4]  = mkOp(3'd1, 32'h8000_0000, 32'd31, 4'h2);
    ops[5]  = mkOp(3'd2, 32'h7FFF_FFFF, 32'd1,  4'h3);
    ops[6]  = mkOp(3'd0, 32'hDEAD_BEEF, 32'd0,  4'h4);
    ops[7]  = mkOp(3'd2, 32'h8000_0001, 32'd32, 4'h8);
    ops[8]  = mkOp(3'd4, 32'h1234_5678, 32'd0,  4'h9);
    ops[9]  = mkOp(3'd5, 32'hCAFE_F00D, 32'd7,  4'hA);
    ops[10] = mkOp(3'd7, 32'h0000_FFFF, 32'd3,  4'hB);
    ops[11] = mkOp(3'd3, 32'h1234_5678, 32'd31, 4'hC);
    outReady = 1'b1;
    foreach (ops[i]) begin
      @(posedge clock); #1;
      driveOp(ops[i]);
      @(negedge clock);
      checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL dir%0d_inReady got=%b want=1", i, inReady); end
      sb.push_back(expect_of(ops[i]));
      @(posedge clock); #1;
      idleInputs();
      lat = 0;
      do begin
        @(negedge clock);
        lat++;
      end while (outValid !== 1'b1 && lat < 10);
      checks++; if (lat != P || outValid !== 1'b1) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, P); end
      if (sb.size() == 0) begin
        checks++; failures++; $display("FAIL dir%0d_scoreboard got=empty want=entry", i);
      end else begin
        e = sb.pop_front();
        checks++; if (result !== e.res) begin failures++; $display("FAIL dir%0d_result got=%h want=%h", i, result, e.res); end
        checks++; if (outTag !== e.tag) begin failures++; $display("FAIL dir%0d_tag got=%h want=%h", i, outTag, e.tag); end
`ifdef SHIFTER_FLAGS_EN
        checks++; if (carryOut !== e.carry || zeroFlag !== (e.res == '0)) begin failures++; $display("FAIL dir%0d_flags got=%b%b want=%b%b", i, carryOut, zeroFlag, e.carry, (e.res == '0)); end
`else
        checks++; if (carryOut !== 1'b0 || zeroFlag !== 1'b0) begin failures++; $display("FAIL dir%0d_flags got=%b%b want=00", i, carryOut, zeroFlag); end
`endif
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    opT  ops[8];
    expT e;
    int  accepted = 0, received = 0, firstOut = -1, lastOut = -1;
    bit  accNow;
    for (int i = 0; i < 8; i++)
      ops[i] = mkOp(3'(i % 6), $urandom, $urandom, 4'(i + 3));
    outReady = 1'b1;
    @(posedge clock); #1;
    driveOp(ops[0]);
    for (int cyc = 0; cyc < 40 && received < 8; cyc++) begin
      @(negedge clock);
      accNow = inValid && inReady;
      if (accepted < 8) begin
        checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL b2b_inReady cyc=%0d got=%b want=1", cyc, inReady); end
      end
      if (outValid === 1'b1) begin
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
        received++;
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_scoreboard got=empty want=entry");
        end else begin
          e = sb.pop_front();
          checks++; if (result !== e.res || outTag !== e.tag) begin failures++; $display("FAIL b2b_result got=%h/%h want=%h/%h", result, outTag, e.res, e.tag); end
        end
      end
      if (accNow) begin
        sb.push_back(expect_of(ops[accepted]));
        accepted++;
      end
      @(posedge clock); #1;
      if (accepted < 8) driveOp(ops[accepted]); else idleInputs();
    end
    checks++; if (received != 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", received); end
    checks++; if (firstOut != P) begin failures++; $display("FAIL b2b_first_latency got=%0d want=%0d", firstOut, P); end
    checks++; if (lastOut - firstOut != 7) begin failures++; $display("FAIL b2b_consecutive got=%0d want=7", lastOut - firstOut); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d want=0", sb.size()); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall();
    opT           ops[6];
    expT          e;
    int           accepted = 0, received = 0, stallAcc = 0;
    bit           accNow, held = 0;
    logic [W-1:0] heldRes;
    logic [T-1:0] heldTag;
    for (int i = 0; i < 6; i++)
      ops[i] = mkOp(3'(i % 5), 32'hA5C3_0F81 ^ (32'(i) << 7), 32'(i * 5 + 1), 4'(9 + i));
    outReady = 1'b0;
    @(posedge clock); #1;
    driveOp(ops[0]);
    for (int cyc = 0; cyc < 40 && received < 6; cyc++) begin
      @(negedge clock);
      accNow = inValid && inReady;
      if (cyc < 5) begin
        if (accNow) stallAcc++;
        if (outValid === 1'b1) begin
          if (!held) begin
            held = 1; heldRes = result; heldTag = outTag;
            checks++; if (heldRes !== model(ops[0])) begin failures++; $display("FAIL stall_head got=%h want=%h", heldRes, model(ops[0])); end
          end else begin
            checks++; if (result !== heldRes || outTag !== heldTag) begin failures++; $display("FAIL stall_stable cyc=%0d got=%h want=%h", cyc, result, heldRes); end
          end
        end
      end
      if (cyc == 4) begin
        checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL stall_inReady got=%b want=0", inReady); end
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        received++;
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL stall_scoreboard got=empty want=entry");
        end else begin
          e = sb.pop_front();
          checks++; if (result !== e.res || outTag !== e.tag) begin failures++; $display("FAIL stall_result got=%h/%h want=%h/%h", result, outTag, e.res, e.tag); end
        end
      end
      if (accNow) begin
        sb.push_back(expect_of(ops[accepted]));
        accepted++;
      end
      @(posedge clock); #1;
      outReady = (cyc >= 4);
      if (accepted < 6) driveOp(ops[accepted]); else idleInputs();
    end
    checks++; if (stallAcc != 2) begin failures++; $display("FAIL stall_accepts got=%0d want=2", stallAcc); end
    checks++; if (received != 6 || accepted != 6) begin failures++; $display("FAIL stall_count got=%0d/%0d want=6/6", received, accepted); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_leftover got=%0d want=0", sb.size()); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    outReady = 1'b0;
    @(posedge clock); #1;
    driveOp(mkOp(3'd1, 32'hFFFF_0000, 32'd8, 4'hD));
    @(posedge clock); #1;
    driveOp(mkOp(3'd0, 32'h0000_FFFF, 32'd8, 4'hE));
    @(posedge clock); #1;
    idleInputs();
    @(negedge clock);
    checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL rmid_inflight got=%b want=1", outValid); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL rmid_outValid got=%b want=0", outValid); end
    checks++; if (result !== '0 || outTag !== '0) begin failures++; $display("FAIL rmid_cleared got=%h/%h want=0/0", result, outTag); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL rmid_inReady got=%b want=1", inReady); end
    sb.delete();
    @(negedge clock);
    resetN   = 1'b1;
    outReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL rmid_stale cyc=%0d got=%b want=0", k, outValid); end
    end
  endtask

  // -------------------------------------------------------------------------
  // PIPE_STAGES=0 instance: everything follows the inputs in the same cycle.
  task automatic test_comb();
    opT ops[6];
    ops[0] = mkOp(3'd0, 32'h8000_0000, 32'd1,  4'h3);
    ops[1] = mkOp(3'd2, 32'h8000_0010, 32'd4,  4'h5);
    ops[2] = mkOp(3'd4, 32'h8000_0001, 32'd1,  4'h6);
    ops[3] = mkOp(3'd3, 32'h8000_0001, 32'd33, 4'h7);
    ops[4] = mkOp(3'd1, 32'h0F0F_0F0F, 32'd0,  4'h8);
    ops[5] = mkOp(3'd6, 32'h1357_9BDF, 32'd9,  4'h9);
    foreach (ops[i]) begin
      @(posedge clock); #1;
      driveOp(ops[i]);
      outReady = (i % 2 == 0);
      @(negedge clock);
      checks++; if (cOutValid !== 1'b1 || cInReady !== outReady) begin failures++; $display("FAIL comb%0d_handshake got=%b%b want=1%b", i, cOutValid, cInReady, outReady); end
      checks++; if (cResult !== model(ops[i]) || cOutTag !== ops[i].tag) begin failures++; $display("FAIL comb%0d_result got=%h/%h want=%h/%h", i, cResult, cOutTag, model(ops[i]), ops[i].tag); end
`ifdef SHIFTER_FLAGS_EN
      checks++; if (cCarryOut !== modelCarry(ops[i]) || cZeroFlag !== (model(ops[i]) == '0)) begin failures++; $display("FAIL comb%0d_flags got=%b%b want=%b%b", i, cCarryOut, cZeroFlag, modelCarry(ops[i]), (model(ops[i]) == '0)); end
`else
      checks++; if (cCarryOut !== 1'b0 || cZeroFlag !== 1'b0) begin failures++; $display("FAIL comb%0d_flags got=%b%b want=00", i, cCarryOut, cZeroFlag); end
`endif
    end
    @(posedge clock); #1;
    idleInputs();
    outReady = 1'b1;
    @(negedge clock);
    checks++; if (cOutValid !== 1'b0) begin failures++; $display("FAIL comb_idle got=%b want=0", cOutValid); end
  endtask

  initial begin
    resetN   = 1'b0;
    outReady = 1'b1;
    idleInputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_comb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
